uart_axi_slv: RTL and testbench
===============================

UART_AXI_SLV -- requirements
Module: uart_axi_slv

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80020000, base of the 256-byte register window on ic0 slave port 3.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (>=4).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 c_sys_rst  input  1  reset, synchronous, active-high.
REQ-005 c_axi_mst_rd_valid  input  1  read request strobe.
REQ-006 axi_mst_rd_addr  input  32  read byte address.
REQ-007 c_axi_mst_wr_valid  input  1  write request strobe.
REQ-008 axi_mst_wr_addr  input  32  write byte address.
REQ-009 axi_mst_wr_data  input  32  write data.
REQ-010 axi_slv_rd_data  output  32  read response data.
REQ-011 c_axi_slv_rd_ready  output  1  read response valid pulse.
REQ-012 uart_tx  output  1  serial out, idle high.
REQ-013 uart_rx  input  1  serial in, asynchronous, idle high.

Function
REQ-014 Register map (offset = addr - BASE_ADDR): 0x10 TX_COM, 0x20 REC, 0x30 RX_COM; request in window iff addr[31:8] == BASE_ADDR[31:8].
REQ-015 Read in window: c_axi_slv_rd_ready high exactly one cycle, the cycle after c_axi_mst_rd_valid; axi_slv_rd_data registered same cycle, 0 when ready low.
REQ-016 Read outside window: no response, ready stays 0; unmapped in-window offset: ready pulses, data 0.
REQ-017 TX_COM read: {31'b0, tx_busy}; write: starts frame with wr_data[7:0] if idle; ignored if busy.
REQ-018 REC read: {24'b0, rx_data}; clears rx_valid.
REQ-019 RX_COM read: {29'b0, frame_err, overrun, rx_valid}; clears overrun and frame_err.
REQ-020 Back-to-back reads every cycle SHALL each get one response, in order.
REQ-021 TX FSM: IDLE -> START (1 bit low) -> DATA (8 bits, LSB first) -> STOP (1 bit high) -> IDLE; each state lasts CLKS_PER_BIT cycles; tx_busy = state != IDLE; frame = 10*CLKS_PER_BIT cycles.
REQ-022 uart_tx SHALL start low the cycle after accepted TX_COM write.
REQ-023 uart_rx through 2-flop synchronizer before use.
REQ-024 RX FSM: IDLE -> START on synchronized falling edge; START samples at CLKS_PER_BIT/2, returns IDLE if high (glitch); DATA samples 8 bits at bit centre; STOP samples stop bit.
REQ-025 Stop bit 0: frame_err set, byte discarded, FSM returns IDLE.
REQ-026 Valid byte with rx_valid=0: rx_data <= byte, rx_valid <= 1.
REQ-027 Valid byte with rx_valid=1: rx_data kept, overrun set (sticky).
REQ-028 REC read coinciding with byte completion: read returns old rx_data; new byte stored, rx_valid stays 1, no overrun.
REQ-029 Simultaneous read and write SHALL both be serviced independently.

Reset
REQ-030 On c_sys_rst: both FSMs IDLE, counters 0, uart_tx=1, c_axi_slv_rd_ready=0, axi_slv_rd_data=0, rx_data=0, rx_valid/overrun/frame_err=0, synchronizer flops=1.
REQ-031 Reset mid-frame SHALL abort TX (uart_tx=1 next cycle) and RX; pending read response dropped.

Configuration
REQ-032 Macro UART_LOOPBACK_EN defined: RX synchronizer input = internal TX serial line, uart_rx ignored, uart_tx held 1.
REQ-033 Macro undefined: RX from uart_rx, uart_tx driven by TX FSM.

Verification (CLKS_PER_BIT=4)
REQ-034 Write 0x80020010 data 0xA5 -> uart_tx low 4 cycles, bits 1,0,1,0,0,1,0,1 at 4 cycles each, high 4; TX_COM read =1 during, 0 after 40 cycles.
REQ-035 Drive frame 0x81 on uart_rx -> RX_COM read =0x1, REC read =0x81, then RX_COM =0x0.
REQ-036 Two frames 0x11, 0x22 without REC read -> REC=0x11, RX_COM=0x3 before REC read.
REQ-037 Frame 0x55 with stop bit 0 -> RX_COM=0x4, rx_valid 0; 1-cycle low glitch on uart_rx -> no byte.
REQ-038 Read 0x80030010 -> no ready; read 0x80020040 -> ready, data 0; reads every cycle to 0x10/0x20/0x30 -> three consecutive ready pulses.
REQ-039 Assert c_sys_rst mid-TX of 0xFF -> uart_tx=1 next cycle, TX_COM read =0 after release.

Source files
------------

// File: rtl/uart_axi_slv.sv
// UART register slave (TX_COM 0x10, REC 0x20, RX_COM 0x30); UART_LOOPBACK_EN routes TX into RX.
// Read response 1 cycle after request, no backpressure; TX_COM writes while busy are dropped.
module uart_axi_slv #(
  parameter logic [31:0] BASE_ADDR    = 32'h80020000,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        c_sys_rst,
  input  logic        c_axi_mst_rd_valid,
  input  logic [31:0] axi_mst_rd_addr,
  input  logic        c_axi_mst_wr_valid,
  input  logic [31:0] axi_mst_wr_addr,
  input  logic [31:0] axi_mst_wr_data,
  output logic [31:0] axi_slv_rd_data,
  output logic        c_axi_slv_rd_ready,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_line;
  logic          tx_busy;

  rx_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_src, rx_ff1, rx_s, rx_prev;
  logic [7:0]    rx_data;
  logic          rx_valid, overrun, frame_err;

  logic rd_win, wr_win, rd_hit, rd_rec, rd_rxc, wr_tx;
  logic stop_smp, byte_ok;
  logic unused;

`ifdef UART_LOOPBACK_EN
  assign rx_src  = tx_line;
  assign uart_tx = 1'b1;
  assign unused  = ^{uart_rx, axi_mst_wr_data[31:8]};
`else
  assign rx_src  = uart_rx;
  assign uart_tx = tx_line;
  assign unused  = ^axi_mst_wr_data[31:8];
`endif

  assign rd_win  = axi_mst_rd_addr[31:8] == BASE_ADDR[31:8];
  assign wr_win  = axi_mst_wr_addr[31:8] == BASE_ADDR[31:8];
  assign rd_hit  = c_axi_mst_rd_valid && rd_win;
  assign rd_rec  = rd_hit && (axi_mst_rd_addr[7:0] == 8'h20);
  assign rd_rxc  = rd_hit && (axi_mst_rd_addr[7:0] == 8'h30);
  assign wr_tx   = c_axi_mst_wr_valid && wr_win && (axi_mst_wr_addr[7:0] == 8'h10);
  assign tx_busy = tx_state != TX_IDLE;

  assign stop_smp = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
  assign byte_ok  = stop_smp && rx_s;

  // Register read port
  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      c_axi_slv_rd_ready <= 1'b0;
      axi_slv_rd_data    <= 32'h0;
    end else begin
      c_axi_slv_rd_ready <= rd_hit;
      axi_slv_rd_data    <= 32'h0;
      if (rd_hit) begin
        case (axi_mst_rd_addr[7:0])
          8'h10:   axi_slv_rd_data <= {31'b0, tx_busy};
          8'h20:   axi_slv_rd_data <= {24'b0, rx_data};
          8'h30:   axi_slv_rd_data <= {29'b0, frame_err, overrun, rx_valid};
          default: axi_slv_rd_data <= 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (wr_tx) begin
            tx_state <= TX_START;
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_sh    <= axi_mst_wr_data[7:0];
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
            tx_line  <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_line <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RX bit timing counts from the detected falling edge; centre of bit = half period later
  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      rx_ff1   <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_ff1  <= rx_src;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // A REC read in the completion cycle frees the holding register, so no overrun then
  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd_rxc) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (byte_ok) begin
        if (!rx_valid || rd_rec) begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_rec) begin
        rx_valid <= 1'b0;
      end
      if (stop_smp && !rx_s) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_axi_slv.sv
// Directed bench for uart_axi_slv at CLKS_PER_BIT=4.
module tb_uart_axi_slv;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        c_sys_rst = 1'b1;
  logic        c_axi_mst_rd_valid = 1'b0;
  logic [31:0] axi_mst_rd_addr = 32'h0;
  logic        c_axi_mst_wr_valid = 1'b0;
  logic [31:0] axi_mst_wr_addr = 32'h0;
  logic [31:0] axi_mst_wr_data = 32'h0;
  logic [31:0] axi_slv_rd_data;
  logic        c_axi_slv_rd_ready;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;

  uart_axi_slv #(.BASE_ADDR(32'h80020000), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .c_sys_rst(c_sys_rst),
    .c_axi_mst_rd_valid(c_axi_mst_rd_valid),
    .axi_mst_rd_addr(axi_mst_rd_addr),
    .c_axi_mst_wr_valid(c_axi_mst_wr_valid),
    .axi_mst_wr_addr(axi_mst_wr_addr),
    .axi_mst_wr_data(axi_mst_wr_data),
    .axi_slv_rd_data(axi_slv_rd_data),
    .c_axi_slv_rd_ready(c_axi_slv_rd_ready),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic r);
    c_axi_mst_rd_valid = 1'b1;
    axi_mst_rd_addr    = a;
    tick();
    c_axi_mst_rd_valid = 1'b0;
    r = c_axi_slv_rd_ready;
    d = axi_slv_rd_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    c_axi_mst_wr_valid = 1'b1;
    axi_mst_wr_addr    = a;
    axi_mst_wr_data    = d;
    tick();
    c_axi_mst_wr_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) tick();
    end
    uart_rx = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic r;
    c_sys_rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (uart_tx !== 1'b1 || c_axi_slv_rd_ready !== 1'b0 || axi_slv_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs tx=%b rdy=%b data=%h required tx=1 rdy=0 data=0", uart_tx, c_axi_slv_rd_ready, axi_slv_rd_data);
    end
    c_sys_rst = 1'b0;
    tick();
    rd(32'h80020030, d, r);
    checks++;
    if (r !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL reset_rxcom rdy=%b data=%h required 1/0", r, d);
    end
    rd(32'h80020010, d, r);
    checks++;
    if (r !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL reset_txcom rdy=%b data=%h required 1/0", r, d);
    end
  endtask

  task automatic test_tx();
    logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    wr(32'h80020010, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (uart_tx !== f[i/CPB]) begin
        errors++;
        $display("FAIL tx_bit cycle=%0d got=%b required=%b", i, uart_tx, f[i/CPB]);
      end
      if (i == 10) begin
        checks++;
        if (c_axi_slv_rd_ready !== 1'b1 || axi_slv_rd_data !== 32'h1) begin
          errors++;
          $display("FAIL tx_busy_during rdy=%b data=%h required 1/1", c_axi_slv_rd_ready, axi_slv_rd_data);
        end
      end
      c_axi_mst_rd_valid = (i == 9);
      axi_mst_rd_addr    = 32'h80020010;
      tick();
    end
    c_axi_mst_rd_valid = 1'b0;
    begin
      logic [31:0] d;
      logic r;
      rd(32'h80020010, d, r);
      checks++;
      if (r !== 1'b1 || d !== 32'h0) begin
        errors++;
        $display("FAIL tx_busy_after rdy=%b data=%h required 1/0", r, d);
      end
    end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic r;
    send_frame(8'h81, 1'b1);
    rd(32'h80020030, d, r);
    checks++;
    if (r !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL rx_status1 rdy=%b data=%h required 1/1", r, d); end
    rd(32'h80020020, d, r);
    checks++;
    if (r !== 1'b1 || d !== 32'h81) begin errors++; $display("FAIL rx_rec rdy=%b data=%h required 1/81", r, d); end
    rd(32'h80020030, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rx_status_clr data=%h required 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic r;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rd(32'h80020030, d, r);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL ovr_status data=%h required 3", d); end
    rd(32'h80020020, d, r);
    checks++;
    if (d !== 32'h11) begin errors++; $display("FAIL ovr_rec data=%h required 11", d); end
    rd(32'h80020030, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ovr_clear data=%h required 0", d); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    logic r;
    send_frame(8'h55, 1'b0);
    rd(32'h80020030, d, r);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL ferr_status data=%h required 4", d); end
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (50) tick();
    rd(32'h80020030, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_status data=%h required 0", d); end
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic r;
    rd(32'h80030010, d, r);
    checks++;
    if (r !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL out_window rdy=%b data=%h required 0/0", r, d); end
    tick();
    checks++;
    if (c_axi_slv_rd_ready !== 1'b0) begin errors++; $display("FAIL out_window_late rdy=%b required 0", c_axi_slv_rd_ready); end
    rd(32'h80020040, d, r);
    checks++;
    if (r !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped rdy=%b data=%h required 1/0", r, d); end
    tick();
    checks++;
    if (c_axi_slv_rd_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle rdy=%b required 0", c_axi_slv_rd_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp   [3];
    send_frame(8'h3C, 1'b1);
    addrs[0] = 32'h80020010; addrs[1] = 32'h80020020; addrs[2] = 32'h80020030;
    exp[0] = 32'h0; exp[1] = 32'h3C; exp[2] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      c_axi_mst_rd_valid = (i < 3);
      axi_mst_rd_addr    = (i < 3) ? addrs[i] : 32'h0;
      tick();
      checks++;
      if (i < 3) begin
        if (c_axi_slv_rd_ready !== 1'b1 || axi_slv_rd_data !== exp[i]) begin
          errors++;
          $display("FAIL b2b_%0d rdy=%b data=%h required 1/%h", i, c_axi_slv_rd_ready, axi_slv_rd_data, exp[i]);
        end
      end else if (c_axi_slv_rd_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_end rdy=%b required 0", c_axi_slv_rd_ready);
      end
    end
    c_axi_mst_rd_valid = 1'b0;
  endtask

  task automatic test_simul();
    c_axi_mst_rd_valid = 1'b1;
    axi_mst_rd_addr    = 32'h80020010;
    c_axi_mst_wr_valid = 1'b1;
    axi_mst_wr_addr    = 32'h80020010;
    axi_mst_wr_data    = 32'h0F;
    tick();
    c_axi_mst_rd_valid = 1'b0;
    c_axi_mst_wr_valid = 1'b0;
    checks++;
    if (c_axi_slv_rd_ready !== 1'b1 || axi_slv_rd_data !== 32'h0 || uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL simul rdy=%b data=%h tx=%b required 1/0/0", c_axi_slv_rd_ready, axi_slv_rd_data, uart_tx);
    end
    repeat (45) tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic r;
    wr(32'h80020010, 32'hFF);
    tick();
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL rst_mid_start tx=%b required 0", uart_tx); end
    c_sys_rst = 1'b1;
    tick();
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx tx=%b required 1", uart_tx); end
    c_sys_rst = 1'b0;
    rd(32'h80020010, d, r);
    checks++;
    if (r !== 1'b1 || d !== 32'h0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_txcom rdy=%b data=%h tx=%b required 1/0/1", r, d, uart_tx);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_frame_err();
    test_window();
    test_back_to_back();
    test_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
